// File: rtl/pipelined_rc_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_rc_adder
//  Description : Ripple-carry adder/subtractor split into STAGES chunk
//                pipelines with valid/ready flow control. Each stage adds one
//                CW-bit chunk, carrying skewed operands and deskewed sum bits
//                forward so no carry chain spans more than one chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rc_adder #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    // Chunk geometry: all chunks are c_cw wide except the last, which takes
    // whatever is left over and must hold at least one bit.
    localparam int c_cw      = (WIDTH + STAGES - 1) / STAGES;
    localparam int c_last_lo = (STAGES - 1) * c_cw;
    localparam int c_last_w  = WIDTH - c_last_lo;
    // Number of intermediate (non-final) stages; arrays keep one dummy entry
    // when the whole adder collapses into a single stage.
    localparam int c_nb      = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_rc_adder: WIDTH must lie in 2..64");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_rc_adder: STAGES must lie in 1..WIDTH");
    end
    if (c_last_w < 1) begin : g_bad_split
        $error("pipelined_rc_adder: WIDTH/STAGES leaves an empty last chunk");
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic              w_xfer;

    // A stage advances if it holds data and somewhere downstream there is a
    // hole, or the output is being consumed (the ready chain, unrolled).
    always_comb begin : p_adv
        logic v_go;
        v_go  = out_ready;
        w_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = r_valid[k] && v_go;
            v_go     = v_go || !r_valid[k];
        end
    end

    assign in_ready = !r_valid[0] || w_adv[0];
    assign w_xfer   = in_valid && in_ready;

    // Stage k is loaded when stage k-1 advances; stage 0 on an input transfer.
    always_comb begin
        w_load    = w_adv << 1;
        w_load[0] = w_xfer;
    end

    // Valid bits: set on load, cleared when the held beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand conditioning: subtract is A + ~B + ~borrow
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    assign w_b_eff = in_sub ? ~in_b : in_b;
    assign w_c_eff = in_sub ^ in_cin;

    // ------------------------------------------------------------------
    // Intermediate stages. r_a holds completed sum bits below the chunk
    // boundary and still-unprocessed A bits above it; r_b carries B.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a     [c_nb];
    logic [WIDTH-1:0] r_b     [c_nb];
    logic             r_c     [c_nb];
    logic [WIDTH-1:0] w_src_a [c_nb];
    logic [WIDTH-1:0] w_src_b [c_nb];
    logic             w_src_c [c_nb];
    logic [WIDTH-1:0] w_nxt_a [c_nb];
    logic [c_cw:0]    w_chunk [c_nb];

    // Chunk adders for the intermediate stages, each limited to c_cw bits.
    always_comb begin
        w_src_a[0] = in_a;
        w_src_b[0] = w_b_eff;
        w_src_c[0] = w_c_eff;
        for (int k = 1; k < c_nb; k++) begin
            w_src_a[k] = r_a[k-1];
            w_src_b[k] = r_b[k-1];
            w_src_c[k] = r_c[k-1];
        end
        for (int k = 0; k < c_nb; k++) begin
            w_chunk[k] = {1'b0, w_src_a[k][k*c_cw +: c_cw]}
                       + {1'b0, w_src_b[k][k*c_cw +: c_cw]}
                       + {{c_cw{1'b0}}, w_src_c[k]};
            w_nxt_a[k] = w_src_a[k];
            w_nxt_a[k][k*c_cw +: c_cw] = w_chunk[k][c_cw-1:0];
        end
    end

    if (STAGES > 1) begin : g_mid
        // Skew/deskew registers; data only, validity is tracked by r_valid.
        always_ff @(posedge clk) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_load[k]) begin
                    r_a[k] <= w_nxt_a[k];
                    r_b[k] <= w_src_b[k];
                    r_c[k] <= w_chunk[k][c_cw];
                end
            end
        end
    end else begin : g_no_mid
        assign r_a[0] = '0;
        assign r_b[0] = '0;
        assign r_c[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Final stage: last chunk, carry out and signed overflow
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  w_last_a;
    logic [WIDTH-1:0]  w_last_b;
    logic              w_last_c;
    logic [c_last_w:0] w_last_chunk;
    logic [WIDTH-1:0]  w_sum_nxt;
    logic              w_ovf_nxt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    if (STAGES == 1) begin : g_last_src_in
        assign w_last_a = in_a;
        assign w_last_b = w_b_eff;
        assign w_last_c = w_c_eff;
    end else begin : g_last_src_pipe
        assign w_last_a = r_a[STAGES-2];
        assign w_last_b = r_b[STAGES-2];
        assign w_last_c = r_c[STAGES-2];
    end

    assign w_last_chunk = {1'b0, w_last_a[c_last_lo +: c_last_w]}
                        + {1'b0, w_last_b[c_last_lo +: c_last_w]}
                        + {{c_last_w{1'b0}}, w_last_c};

    // Merge the final chunk into the already-completed lower sum bits.
    always_comb begin
        w_sum_nxt = w_last_a;
        w_sum_nxt[c_last_lo +: c_last_w] = w_last_chunk[c_last_w-1:0];
    end

    // Carry into the MSB is recovered as sum ^ a ^ b at that bit position.
    assign w_ovf_nxt = w_last_chunk[c_last_w]
                     ^ (w_sum_nxt[WIDTH-1] ^ w_last_a[WIDTH-1] ^ w_last_b[WIDTH-1]);

    // Output registers; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load[STAGES-1]) begin
            r_sum  <= w_sum_nxt;
            r_cout <= w_last_chunk[c_last_w];
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;

    // Bits that are structurally dead in some configurations (B bits already
    // consumed by earlier chunks, single-stage placeholders) are folded here.
    logic w_unused;
    always_comb begin
        w_unused = ^w_last_b;
        for (int k = 0; k < c_nb; k++) begin
            w_unused = w_unused ^ (^r_a[k]) ^ (^r_b[k]) ^ r_c[k]
                     ^ (^w_nxt_a[k]) ^ (^w_chunk[k]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_rc_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_rc_adder
//  Description : Directed and random stimulus for pipelined_rc_adder
//                (WIDTH=10, STAGES=2) with a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_rc_adder;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_mode = 1'b0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    pipelined_rc_adder #(.WIDTH(W), .STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain wide addition with two's-complement overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   f;
        logic         ov;
        be = sub ? ~b : b;
        ce = sub ^ cin;
        f  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        ov = (a[W-1] == be[W-1]) && (f[W-1] != a[W-1]);
        return {ov, f[W], f[W-1:0]};
    endfunction

    task automatic set_rand();
        logic [W+1:0] r;
        in_a   = W'($urandom_range(1023, 0));
        in_b   = W'($urandom_range(1023, 0));
        in_cin = 1'($urandom_range(1, 0));
        in_sub = 1'($urandom_range(1, 0));
        r = model(in_a, in_b, in_cin, in_sub);
        cur.sum  = r[W-1:0];
        cur.cout = r[W];
        cur.ovf  = r[W+1];
    endtask

    task automatic set_exp(input int a, input int b, input bit cin, input bit sub,
                           input int s, input bit co, input bit ov);
        in_a     = W'(a);
        in_b     = W'(b);
        in_cin   = cin;
        in_sub   = sub;
        cur.sum  = W'(s);
        cur.cout = co;
        cur.ovf  = ov;
    endtask

    // One clock: score the output beat, record an accepted input, advance.
    task automatic tick(output bit xfer);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                chk("sum", out_sum, sb[0].sum);
                chk("cout", out_cout, sb[0].cout);
                chk("ovf", out_ovf, sb[0].ovf);
                if (out_ready) begin
                    if (lat_mode) chk("latency", cyc - sb[0].acc, 2);
                    void'(sb.pop_front());
                end
            end
        end
        xfer = in_valid && in_ready;
        if (xfer) begin
            exp_t e;
            e     = cur;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send();
        bit x;
        int n;
        n = 0;
        in_valid = 1'b1;
        do begin
            tick(x);
            n++;
        end while (!x && n < 20);
        chk("accept", x, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        bit x;
        int n;
        n = 0;
        while (sb.size() > 0 && n < max) begin
            tick(x);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        bit x;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Directed corner cases
        lat_mode = 1'b1;
        set_exp(1023, 1, 0, 0, 0, 1, 0);    send(); drain(10);
        set_exp(511, 1, 0, 0, 512, 0, 1);   send(); drain(10);
        set_exp(512, 512, 0, 0, 0, 1, 1);   send(); drain(10);
        set_exp(5, 7, 0, 1, 1022, 0, 0);    send(); drain(10);
        set_exp(7, 5, 1, 1, 1, 1, 0);       send(); drain(10);

        // Back-to-back random stream
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rand();
            tick(x);
            chk("stream_accept", x, 1);
        end
        in_valid = 1'b0;
        drain(10);

        // Output stall: pipe fills with two beats then blocks
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_rand();
        for (int i = 0; i < 5; i++) begin
            tick(x);
            if (x) set_rand();
            if (i >= 1) chk("stall_in_ready", in_ready, 0);
        end
        chk("stall_occupancy", sb.size(), 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(10);

        // Reset with two beats in flight
        lat_mode = 1'b1;
        in_valid = 1'b1;
        set_rand(); tick(x);
        set_rand(); tick(x);
        in_valid = 1'b0;
        chk("inflight_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(x);
            chk("post_rst_idle", out_valid, 0);
        end
        set_rand(); send(); drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_rc_adder.md
PIPELINED_RC_ADDER -- requirements
Module: pipelined_rc_adder

Interface
REQ-001 Parameter WIDTH, default 10: operand and sum width in bits; legal range 2..64.
REQ-002 Parameter STAGES, default 2: number of pipeline register stages; legal range 1..WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  the operand beat on in_* is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in (add mode) or borrow-in (subtract mode).
REQ-010 in_sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  the result beat on out_* is valid.
REQ-012 out_ready  input  1  the downstream consumer accepts the result beat.
REQ-013 out_sum  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 out_cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 Operand width is split into STAGES chunks of CW = ceil(WIDTH/STAGES) bits, LSB first; the last chunk holds the remaining WIDTH-(STAGES-1)*CW bits and is never empty. Configurations where that remainder is 0 or negative are illegal and are rejected at elaboration.
REQ-017 Stage k adds chunk k, using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-018 Effective B = in_sub ? ~in_b : in_b, and effective carry-in = in_sub ? ~in_cin : in_cin, so subtract computes A - B - in_cin.
REQ-019 Unprocessed upper operand chunks, completed lower sum chunks, and the inter-chunk carry are registered alongside each stage (skew/deskew registers). No combinational carry chain is longer than CW bits.
REQ-020 Each stage holds a valid bit. A stage advances when its successor is empty or is itself advancing; the last stage advances when out_ready = 1.
REQ-021 in_ready = !valid[0] || advance[0]; a transfer occurs when in_valid && in_ready.
REQ-022 out_valid = valid[STAGES-1]; out_sum, out_cout and out_ovf are driven directly from last-stage registers.
REQ-023 Latency is exactly STAGES cycles from input transfer to out_valid, given no stall.
REQ-024 Throughput is 1 beat/cycle while out_ready = 1.
REQ-025 Bubbles collapse: an empty stage accepts data even while the output is stalled.
REQ-026 While out_valid = 1 && out_ready = 0, out_* hold stable and no data is lost or duplicated.
REQ-027 Simultaneous input transfer and output transfer in the same cycle with a full pipe is legal; occupancy is unchanged.
REQ-028 Beats exit in acceptance order.
REQ-029 out_ovf is computed in the final stage only, from the MSB carry-in and carry-out.
REQ-030 With STAGES = 1, the block is a single registered adder with a skid-free valid/ready register.

Reset
REQ-031 rst_n = 0 asynchronously clears all valid bits: out_valid = 0.
REQ-032 On reset, out_sum = 0, out_cout = 0 and out_ovf = 0.
REQ-033 in_ready = 1 from the first cycle after rst_n deasserts.
REQ-034 Reset mid-operation discards all in-flight beats; no result from before reset ever appears on the output.
REQ-035 Data registers other than the output registers need no reset.

Verification (WIDTH=10, STAGES=2)
REQ-036 Add a=1023, b=1, cin=0 -> after 2 cycles: sum=0, cout=1, ovf=0.
REQ-037 Add a=511, b=1, cin=0 -> sum=512, cout=0, ovf=1; add a=512, b=512 -> sum=0, cout=1, ovf=1.
REQ-038 Subtract a=5, b=7, cin=0 -> sum=1022, cout=0, ovf=0; subtract a=7, b=5, cin=1 -> sum=1, cout=1.
REQ-039 Stream 20 random beats back-to-back with out_ready=1 -> 20 consecutive out_valid cycles starting 2 cycles after the first beat, each matching the reference model.
REQ-040 Hold out_ready=0 for 5 cycles with in_valid=1 -> pipe fills with 2 beats and in_ready=0; out_* stay stable. Release out_ready -> beats drain in order with no loss.
REQ-041 Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 immediately. No stale result appears; the next accepted beat emerges 2 cycles after acceptance.
